// File: rtl/mod_sram_arbiter.sv
// ---------------------------------------------------------------------------
// mod_sram_arbiter
//
// Shares the single SRAM controller request port between the instruction
// cache (I), the data cache (D) and the VGA frame reader (V). One
// transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Priority: V beats the CPU until it has won VGA_MAX_CONSEC grants in a row
// while a CPU request was waiting. Then the CPU gets one grant. D and I
// alternate when both request. A watchdog in WAIT aborts a transaction
// after TIMEOUT cycles. The abort returns 32'hDEADBEEF and pulses err
// together with the ack.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   i_req/i_addr              instruction read request (held until i_ack)
//   i_ack/i_rdata             one-cycle completion pulse + read data
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack)
//   d_ack/d_rdata             one-cycle completion pulse + read data
//   v_req/v_addr              VGA read request (held until v_ack)
//   v_ack/v_rdata             one-cycle completion pulse + read data
//   mem_req                   one-cycle issue strobe to the SRAM controller
//   mem_we/addr/wdata         registered transaction attributes
//   mem_rdata/mem_rdy         controller read data and completion
//   grant                     current owner: 00 none, 01 I, 10 D, 11 V
//   busy                      high in any state other than IDLE
//   err                       one-cycle pulse on timeout abort, with the ack
// ---------------------------------------------------------------------------
module mod_sram_arbiter #(
    parameter int TIMEOUT        = 255,
    parameter int VGA_MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        v_req,
    input  logic [31:0] v_addr,
    output logic        v_ack,
    output logic [31:0] v_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err
);

    // The VGA run counter is at least 3 bits wide and always wide enough to
    // hold VGA_MAX_CONSEC.
    localparam int VCW = ($clog2(VGA_MAX_CONSEC + 1) > 3) ? $clog2(VGA_MAX_CONSEC + 1) : 3;

    localparam logic [7:0]     TIMEOUT_C    = 8'(TIMEOUT);
    localparam logic [VCW-1:0] VGA_MAX_C    = VCW'(VGA_MAX_CONSEC);
    localparam logic [31:0]    TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;
    localparam logic [1:0] GRANT_V    = 2'b11;

    // last_cpu_r remembers which CPU port won most recently
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t          state_r;
    logic [7:0]      tmo_cnt_r;
    logic [VCW-1:0]  vga_cnt_r;
    logic            last_cpu_r;

    logic            cpu_pend_s;
    logic            vga_capped_s;
    logic [1:0]      win_s;
    logic            win_we_s;
    logic [31:0]     win_addr_s;
    logic [31:0]     win_wdata_s;
    logic [VCW-1:0]  vga_cnt_nxt_s;
    logic            resp_done_s;
    logic            resp_err_s;
    logic [31:0]     resp_data_s;

    // Arbitration for the current IDLE cycle: pick the winner and its attributes.
    always_comb begin
        cpu_pend_s   = i_req | d_req;
        vga_capped_s = (vga_cnt_r == VGA_MAX_C) && cpu_pend_s;

        if (v_req && !vga_capped_s) begin
            win_s = GRANT_V;
        end else if (i_req && d_req) begin
            // Prefer the CPU port that was not served last.
            win_s = (last_cpu_r == LAST_D) ? GRANT_I : GRANT_D;
        end else if (d_req) begin
            win_s = GRANT_D;
        end else if (i_req) begin
            win_s = GRANT_I;
        end else begin
            win_s = GRANT_NONE;
        end

        case (win_s)
            GRANT_I: begin
                win_we_s    = 1'b0;
                win_addr_s  = i_addr;
                win_wdata_s = 32'h0000_0000;
            end
            GRANT_D: begin
                win_we_s    = d_we;
                win_addr_s  = d_addr;
                win_wdata_s = d_we ? d_wdata : 32'h0000_0000;
            end
            GRANT_V: begin
                win_we_s    = 1'b0;
                win_addr_s  = v_addr;
                win_wdata_s = 32'h0000_0000;
            end
            default: begin
                win_we_s    = 1'b0;
                win_addr_s  = 32'h0000_0000;
                win_wdata_s = 32'h0000_0000;
            end
        endcase

        // The VGA run only grows while the CPU is kept waiting.
        if (!cpu_pend_s) begin
            vga_cnt_nxt_s = '0;
        end else if (win_s == GRANT_V) begin
            vga_cnt_nxt_s = (vga_cnt_r < VGA_MAX_C) ? (vga_cnt_r + VCW'(1)) : vga_cnt_r;
        end else begin
            vga_cnt_nxt_s = '0;
        end
    end

    // Completion decode for WAIT: controller ready wins over the watchdog.
    always_comb begin
        if (mem_rdy) begin
            resp_done_s = 1'b1;
            resp_err_s  = 1'b0;
            resp_data_s = mem_we ? 32'h0000_0000 : mem_rdata;
        end else if (tmo_cnt_r == TIMEOUT_C) begin
            resp_done_s = 1'b1;
            resp_err_s  = 1'b1;
            resp_data_s = TIMEOUT_DATA;
        end else begin
            resp_done_s = 1'b0;
            resp_err_s  = 1'b0;
            resp_data_s = 32'h0000_0000;
        end
    end

    // Transaction FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= 8'd0;
            vga_cnt_r  <= '0;
            last_cpu_r <= LAST_I;
            grant      <= GRANT_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            v_ack      <= 1'b0;
            i_rdata    <= 32'h0000_0000;
            d_rdata    <= 32'h0000_0000;
            v_rdata    <= 32'h0000_0000;
            err        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    vga_cnt_r <= vga_cnt_nxt_s;
                    if (win_s != GRANT_NONE) begin
                        grant     <= win_s;
                        mem_req   <= 1'b1;
                        mem_we    <= win_we_s;
                        mem_addr  <= win_addr_s;
                        mem_wdata <= win_wdata_s;
                        if (win_s == GRANT_I) begin
                            last_cpu_r <= LAST_I;
                        end else if (win_s == GRANT_D) begin
                            last_cpu_r <= LAST_D;
                        end else begin
                            last_cpu_r <= last_cpu_r;
                        end
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    mem_req   <= 1'b0;
                    tmo_cnt_r <= 8'd0;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (resp_done_s) begin
                        state_r <= ST_RESP;
                        err     <= resp_err_s;
                        case (grant)
                            GRANT_I: begin
                                i_ack   <= 1'b1;
                                i_rdata <= resp_data_s;
                            end
                            GRANT_D: begin
                                d_ack   <= 1'b1;
                                d_rdata <= resp_data_s;
                            end
                            GRANT_V: begin
                                v_ack   <= 1'b1;
                                v_rdata <= resp_data_s;
                            end
                            default: begin
                                // Ownerless transaction: drop it silently.
                                state_r <= ST_IDLE;
                                err     <= 1'b0;
                            end
                        endcase
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    v_ack   <= 1'b0;
                    i_rdata <= 32'h0000_0000;
                    d_rdata <= 32'h0000_0000;
                    v_rdata <= 32'h0000_0000;
                    err     <= 1'b0;
                    grant   <= GRANT_NONE;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    grant   <= GRANT_NONE;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // busy is the only output decoded directly from state.
    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mod_sram_arbiter.sv
// Self-checking bench for mod_sram_arbiter: directed scenarios followed by
// random request traffic compared against a transaction-level model.
module tb_mod_sram_arbiter;

    localparam int TMO  = 8;
    localparam int VMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, v_req, mem_rdy;
    logic [31:0] i_addr, d_addr, d_wdata, v_addr, mem_rdata;
    logic        i_ack, d_ack, v_ack, mem_req, mem_we, busy, err;
    logic [31:0] i_rdata, d_rdata, v_rdata, mem_addr, mem_wdata;
    logic [1:0]  grant;

    mod_sram_arbiter #(.TIMEOUT(TMO), .VGA_MAX_CONSEC(VMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;

    // SRAM controller model
    logic [31:0] mem_m [logic [31:0]];
    bit          ctl_pending, ctl_never, ctl_we, rdy_force;
    int          ctl_cd, ctl_lat;
    logic [31:0] ctl_addr, ctl_wdata, exp_rdata;

    // Arbitration reference state
    bit          model_on, rdy_prev, busy_prev, last_d;
    int          consec;
    logic [1:0]  own;

    // Directed-scenario scratch
    logic [1:0]  gseq[$];
    int          n_ack, ack_step, found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Advance one cycle (to the next falling edge), run the controller model
    // and, when enabled, compare the DUT against the arbitration rules.
    task automatic step();
        logic [1:0] w;
        logic       cpu;
        logic [2:0] exp_ack;
        @(negedge clk);
        rdy_prev = mem_rdy;
        mem_rdy  = rdy_force;
        if (ctl_pending) begin
            if (ctl_cd == 0) begin
                mem_rdy = 1'b1;
                if (ctl_we) begin
                    exp_rdata = 32'h0;
                    mem_m[ctl_addr] = ctl_wdata;
                    mem_rdata = $urandom();
                end else begin
                    exp_rdata = mem_read(ctl_addr);
                    mem_rdata = exp_rdata;
                end
                ctl_pending = 1'b0;
            end else begin
                ctl_cd--;
            end
        end
        if (mem_req === 1'b1) begin
            ctl_pending = !ctl_never;
            ctl_cd      = ctl_lat;
            ctl_we      = mem_we;
            ctl_addr    = mem_addr;
            ctl_wdata   = mem_wdata;
            issue_cnt++;
        end
        if (model_on) begin
            exp_ack = 3'b000;
            if (rdy_prev) begin
                case (own)
                    2'b01:   exp_ack = 3'b100;
                    2'b10:   exp_ack = 3'b010;
                    2'b11:   exp_ack = 3'b001;
                    default: exp_ack = 3'b000;
                endcase
            end
            check("acks_err", {28'h0, err, i_ack, d_ack, v_ack}, {28'h0, 1'b0, exp_ack});
            if (exp_ack[2]) check("i_rdata", i_rdata, exp_rdata);
            if (exp_ack[1]) check("d_rdata", d_rdata, exp_rdata);
            if (exp_ack[0]) check("v_rdata", v_rdata, exp_rdata);
            if (!busy_prev) begin
                // Previous cycle was IDLE: the request lines still show what it sampled.
                cpu = i_req | d_req;
                if (v_req && !(consec >= VMAX && cpu)) w = 2'b11;
                else if (i_req && d_req) w = last_d ? 2'b01 : 2'b10;
                else if (d_req) w = 2'b10;
                else if (i_req) w = 2'b01;
                else w = 2'b00;
                check1("mem_req_issue", mem_req, w != 2'b00);
                if (w != 2'b00) begin
                    check("grant", {30'h0, grant}, {30'h0, w});
                    if (w == 2'b01) begin
                        check("mem_addr_i", mem_addr, i_addr);
                        check1("mem_we_i", mem_we, 1'b0);
                        last_d = 1'b0;
                    end else if (w == 2'b10) begin
                        check("mem_addr_d", mem_addr, d_addr);
                        check1("mem_we_d", mem_we, d_we);
                        if (d_we) check("mem_wdata_d", mem_wdata, d_wdata);
                        last_d = 1'b1;
                    end else begin
                        check("mem_addr_v", mem_addr, v_addr);
                        check1("mem_we_v", mem_we, 1'b0);
                    end
                    own = w;
                end
                if (!cpu) consec = 0;
                else if (w == 2'b11) consec = (consec < VMAX) ? consec + 1 : consec;
                else consec = 0;
            end else begin
                check1("mem_req_busy", mem_req, 1'b0);
            end
        end
        busy_prev = busy;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {23'h0, i_ack, d_ack, v_ack, mem_req, mem_we, busy, err, grant},
              32'h0);
        check({tag, "_rdata"}, i_rdata | d_rdata | v_rdata, 32'h0);
        check({tag, "_mem"}, mem_addr | mem_wdata, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; v_req = 1'b0;
        rdy_force = 1'b0; ctl_pending = 1'b0; ctl_never = 1'b0;
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst = 1'b1;
        busy_prev = 1'b0; consec = 0; last_d = 1'b0; own = 2'b00;
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; v_req = 1'b0; d_we = 1'b0; mem_rdy = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; v_addr = 32'h0; mem_rdata = 32'h0;
        ctl_lat = 0; model_on = 1'b0;
        #2;

        // Single I read with minimum controller latency
        do_reset();
        mem_m[32'h100] = 32'h1234_5678;
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check1("t1_mem_req", mem_req, 1'b1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_grant_issue", {30'h0, grant}, 32'h1);
        check1("t1_busy", busy, 1'b1);
        step();
        check1("t1_req_once", mem_req, 1'b0);
        check1("t1_no_early_ack", i_ack, 1'b0);
        step();
        check1("t1_ack", i_ack, 1'b1);
        check("t1_rdata", i_rdata, 32'h1234_5678);
        check("t1_grant_resp", {30'h0, grant}, 32'h1);
        i_req = 1'b0;
        step();
        check1("t1_ack_pulse", i_ack, 1'b0);
        check1("t1_idle", busy, 1'b0);
        check("t1_grant_idle", {30'h0, grant}, 32'h0);

        // D write and I read together: D first, then alternating
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
        i_req = 1'b1; i_addr = 32'h104;
        gseq.delete();
        for (int k = 0; k < 40 && gseq.size() < 4; k++) begin
            step();
            if (d_ack) check("t2_write_rdata", d_rdata, 32'h0);
            if (mem_req) begin
                gseq.push_back(grant);
                if (gseq.size() == 1) begin
                    check1("t2_mem_we", mem_we, 1'b1);
                    check("t2_mem_wdata", mem_wdata, 32'hCAFE_F00D);
                    check("t2_mem_addr", mem_addr, 32'h200);
                end
            end
        end
        check("t2_grant_count", 32'(gseq.size()), 32'd4);
        for (int j = 0; j < 4; j++)
            if (j < gseq.size())
                check("t2_grant_seq", {30'h0, gseq[j]}, (j % 2 == 0) ? 32'h2 : 32'h1);

        // VGA starvation bound
        do_reset();
        v_req = 1'b1; v_addr = 32'h8000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        gseq.delete();
        for (int k = 0; k < 80 && gseq.size() < 10; k++) begin
            step();
            if (v_ack) check("t3_v_rdata", v_rdata, mem_read(32'h8000));
            if (mem_req) gseq.push_back(grant);
        end
        check("t3_grant_count", 32'(gseq.size()), 32'd10);
        for (int j = 0; j < 10; j++)
            if (j < gseq.size())
                check("t3_grant_seq", {30'h0, gseq[j]}, (j % 5 == 4) ? 32'h2 : 32'h3);

        // Watchdog timeout, then a late ready in IDLE
        do_reset();
        ctl_never = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        step();
        check1("t4_mem_req", mem_req, 1'b1);
        n_ack = 0;
        for (int k = 0; k < TMO + 1; k++) begin
            step();
            if (d_ack || err) n_ack++;
        end
        check("t4_early_ack", 32'(n_ack), 32'd0);
        step();
        check1("t4_ack", d_ack, 1'b1);
        check1("t4_err", err, 1'b1);
        check("t4_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();
        check1("t4_err_pulse", err, 1'b0);
        rdy_force = 1'b1; mem_rdata = 32'h1111_1111;
        n_ack = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (i_ack || d_ack || v_ack || err || mem_req || busy) n_ack++;
        end
        check("t4_late_rdy_ignored", 32'(n_ack), 32'd0);
        rdy_force = 1'b0; ctl_never = 1'b0;

        // Reset in WAIT aborts; a fresh ISSUE follows release
        do_reset();
        ctl_lat = 5;
        i_req = 1'b1; i_addr = 32'h500;
        step();
        step();
        step();
        check1("t5_in_wait", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_abort");
        ctl_pending = 1'b0;
        step();
        check1("t5_no_ack", i_ack, 1'b0);
        rst = 1'b1;
        n_ack = 0; found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            step();
            if (i_ack) n_ack++;
            if (mem_req) begin
                found = 1;
                check("t5_reissue_addr", mem_addr, 32'h500);
            end
        end
        check("t5_reissued", 32'(found), 32'd1);
        check("t5_no_stale_ack", 32'(n_ack), 32'd0);
        for (int k = 0; k < 20 && n_ack == 0; k++) begin
            step();
            if (i_ack) n_ack++;
        end
        check("t5_fresh_ack", 32'(n_ack), 32'd1);
        i_req = 1'b0;

        // Request held one cycle past the ack starts a second transaction
        do_reset();
        ctl_lat = 0;
        i_req = 1'b1; i_addr = 32'h600;
        issue_cnt = 0; n_ack = 0; ack_step = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (i_ack) begin
                n_ack++;
                if (n_ack == 1) ack_step = k;
            end
            if (ack_step >= 0 && k == ack_step + 2) i_req = 1'b0;
        end
        check("t6_issues", 32'(issue_cnt), 32'd2);
        check("t6_acks", 32'(n_ack), 32'd2);

        // Random traffic against the reference model
        do_reset();
        issue_cnt = 0;
        model_on = 1'b1;
        for (int k = 0; k < 800; k++) begin
            step();
            ctl_lat = $urandom_range(0, 3);
            if (i_ack) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 99) < 35) begin
                i_req = 1'b1; i_addr = 32'($urandom_range(0, 31)) << 2;
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 99) < 35) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 31)) << 2; d_wdata = $urandom();
            end
            if (v_ack) v_req = 1'b0;
            else if (!v_req && $urandom_range(0, 99) < 50) begin
                v_req = 1'b1; v_addr = 32'($urandom_range(0, 31)) << 2;
            end
        end
        model_on = 1'b0;
        check1("rand_traffic_flowed", issue_cnt > 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
